// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// seg7_pkg : shared constants and types for the 8-digit seven-segment scanner
// Revision : 1.0
// ============================================================================
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] NA_OFF  = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a} glyphs with dp off; element n is hex digit n.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
  } disp_t;

  function automatic logic [7:0] digit_sel(input logic [2:0] idx);
    return ~(8'd1 << idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// seg7_decode : combinational hex nibble to active-low segment decode
// Revision    : 1.0
// ============================================================================
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib][6:0];

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// seg7_scan : 8-digit multiplexed seven-segment driver with tear-free update
// Revision  : 1.0
// ============================================================================
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DATA,
  input  logic [7:0]  DP,
  input  logic        LOAD,
  input  logic        BLANK_LZ,
  output logic [7:0]  NA,
  output logic [7:0]  SEG,
  output logic        FRAME
);

  localparam logic [19:0] CNT_LAST = 20'(SCAN_DIV - 1);
  localparam logic [2:0]  IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  disp_t       disp_q, disp_d;
  disp_t       pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic [7:0]  na_q, na_d;
  logic [7:0]  seg_q, seg_d;
  logic        frame_q, frame_d;

  logic        tick;
  logic        commit;
  logic        lead_zero;
  logic [3:0]  cur_nib;
  logic [6:0]  glyph;

  assign cur_nib = disp_q.data[{idx_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .nib (cur_nib),
    .seg (glyph)
  );

  always_comb begin
    tick    = (cnt_q == CNT_LAST);
    commit  = tick && (idx_q == IDX_LAST);
    cnt_d   = tick ? 20'd0 : cnt_q + 20'd1;
    idx_d   = tick ? idx_q + 3'd1 : idx_q;
    frame_d = commit;

    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    disp_d   = disp_q;
    if (LOAD) begin
      pend_d = '{data: DATA, dp: DP};
    end
    // The display only changes at the frame wrap; a coinciding LOAD bypasses pending.
    if (commit) begin
      pend_v_d = 1'b0;
      if (LOAD) begin
        disp_d = '{data: DATA, dp: DP};
      end else if (pend_v_q) begin
        disp_d = pend_q;
      end
    end else if (LOAD) begin
      pend_v_d = 1'b1;
    end

    lead_zero = (idx_q != 3'd0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= int'(idx_q)) && (disp_q.data[4*k +: 4] != 4'd0)) begin
        lead_zero = 1'b0;
      end
    end

    seg_d[6:0] = (BLANK_LZ && lead_zero) ? 7'h7F : glyph;
    seg_d[7]   = ~disp_q.dp[idx_q];
    na_d       = digit_sel(idx_q);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q    <= 20'd0;
      idx_q    <= 3'd0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      na_q     <= NA_OFF;
      seg_q    <= SEG_OFF;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      na_q     <= na_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end

  assign NA    = na_q;
  assign SEG   = seg_q;
  assign FRAME = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// tb_seg7_scan : randomized and directed bench against a cycle-count model
// Revision     : 1.0
// ============================================================================
module tb_seg7_scan;

  localparam int SCAN_DIV  = 4;
  localparam int FRAME_CYC = SCAN_DIV * 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] DATA = '0;
  logic [7:0]  DP = '0;
  logic        LOAD = 1'b0;
  logic        BLANK_LZ = 1'b0;
  logic [7:0]  NA;
  logic [7:0]  SEG;
  logic        FRAME;

  int n_checks = 0;
  int n_errors = 0;

  // Model: t counts cycles since reset release; digit shown = (t / SCAN_DIV) % 8.
  int          t;
  logic [31:0] m_data, p_data;
  logic [7:0]  m_dp, p_dp;
  logic        p_v;

  seg7_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DATA     (DATA),
    .DP       (DP),
    .LOAD     (LOAD),
    .BLANK_LZ (BLANK_LZ),
    .NA       (NA),
    .SEG      (SEG),
    .FRAME    (FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic [7:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] ref_seg(input int k, input logic [31:0] d,
                                         input logic [7:0] dp, input logic blz);
    logic [7:0] s;
    s = ref_glyph(d[4*k +: 4]);
    if (blz && k > 0 && (d >> (4*k)) == 32'd0) s = 8'hFF;
    if (dp[k]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic step();
    int         k;
    logic [7:0] e_na, e_seg;
    logic       e_frame;
    bit         wrap;
    k       = (t / SCAN_DIV) % 8;
    wrap    = (t % FRAME_CYC) == FRAME_CYC - 1;
    e_na    = ~(8'd1 << k);
    e_seg   = ref_seg(k, m_data, m_dp, BLANK_LZ);
    e_frame = wrap;
    if (wrap) begin
      if (LOAD) begin
        m_data = DATA; m_dp = DP; p_v = 1'b0;
      end else if (p_v) begin
        m_data = p_data; m_dp = p_dp; p_v = 1'b0;
      end
    end else if (LOAD) begin
      p_data = DATA; p_dp = DP; p_v = 1'b1;
    end
    @(posedge CLK); #1;
    t++;
    check("NA", NA, e_na);
    check("SEG", SEG, e_seg);
    check("FRAME", FRAME, e_frame);
    check("pend_v", dut.pend_v_q, p_v);
  endtask

  task automatic release_rst();
    @(negedge CLK);
    RST = 1'b1;
    t = 0; m_data = '0; m_dp = '0; p_data = '0; p_dp = '0; p_v = 1'b0;
  endtask

  task automatic run_to(input int phase);
    while ((t % FRAME_CYC) != phase) step();
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] dp);
    DATA = d; DP = dp; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
  endtask

  // After this returns, NA/SEG show digit k.
  task automatic show(input int k);
    run_to(k * SCAN_DIV);
    step();
  endtask

  logic [7:0] blank_exp [8] = '{8'h92, 8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    t = 0; m_data = '0; m_dp = '0; p_data = '0; p_dp = '0; p_v = 1'b0;
    #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    check("rst_na", NA, 8'hFF);
    check("rst_seg", SEG, 8'hFF);
    check("rst_frame", FRAME, 1'b0);
    release_rst();
    step();
    check("rel_na", NA, 8'hFE);
    check("rel_seg", SEG, 8'hC0);

    // Tear-free update: load at digit 3, old contents persist until the wrap.
    run_to(3 * SCAN_DIV);
    load(32'h12345678, 8'h00);
    check("tf_d3", SEG, 8'hC0);
    for (int k = 4; k < 8; k++) begin
      show(k);
      check("tf_old", SEG, 8'hC0);
    end
    show(0);
    check("tf_d0_na", NA, 8'hFE);
    check("tf_d0_seg", SEG, 8'h80);
    show(7);
    check("tf_d7_na", NA, 8'h7F);
    check("tf_d7_seg", SEG, 8'hF9);

    // Reset mid-scan discards the pending load.
    run_to(5);
    load(32'hDEADBEEF, 8'hFF);
    repeat (6) step();
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("mid_rst_na", NA, 8'hFF);
    check("mid_rst_seg", SEG, 8'hFF);
    check("mid_rst_frame", FRAME, 1'b0);
    check("mid_rst_pv", dut.pend_v_q, 1'b0);
    release_rst();
    step();
    check("mid_rel_na", NA, 8'hFE);
    check("mid_rel_seg", SEG, 8'hC0);
    repeat (2 * FRAME_CYC) step();

    // Leading-zero blanking.
    BLANK_LZ = 1'b1;
    load(32'h00000A05, 8'h00);
    for (int k = 0; k < 8; k++) begin
      show(k);
      check("lz_a05", SEG, blank_exp[k]);
    end
    load(32'h0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      show(k);
      check("lz_zero", SEG, (k == 0) ? 8'hC0 : 8'hFF);
    end

    // LOAD on the commit tick overrides an earlier pending value.
    BLANK_LZ = 1'b0;
    run_to(8);
    load(32'h11111111, 8'h00);
    run_to(FRAME_CYC - 1);
    load(32'h22222222, 8'h00);
    check("coin_pv", dut.pend_v_q, 1'b0);
    show(0);
    check("coin_d0", SEG, 8'hA4);
    show(0);
    check("coin_next", SEG, 8'hA4);

    // Decimal points, including on a blanked digit.
    BLANK_LZ = 1'b1;
    load(32'h00000008, 8'h81);
    show(0);
    check("dp_d0", SEG, 8'h00);
    show(7);
    check("dp_d7", SEG, 8'h7F);

    // Randomized traffic against the model.
    repeat (1500) begin
      LOAD = ($urandom % 12) == 0;
      DATA = $urandom >> $urandom_range(0, 32);
      DP   = 8'($urandom);
      if (($urandom % 50) == 0) BLANK_LZ = ~BLANK_LZ;
      step();
    end
    LOAD = 1'b0;
    repeat (FRAME_CYC) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, giving the number of CLK cycles each digit is lit (legal range 2..2^20).
REQ-002 SHALL have port CLK  in  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port DATA  in  32  eight hex nibbles to display; nibble k (DATA[4k+3:4k]) maps to digit k, and digit 0 is the rightmost.
REQ-005 SHALL have port DP  in  8  decimal-point enable per digit; bit k lights the dp of digit k.
REQ-006 SHALL have port LOAD  in  1  one-cycle strobe that captures DATA and DP.
REQ-007 SHALL have port BLANK_LZ  in  1  leading-zero blanking enable.
REQ-008 SHALL have port NA  out  8  active-low anode select; bit k low means digit k is lit.
REQ-009 SHALL have port SEG  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-010 SHALL have port FRAME  out  1  one-cycle pulse marking the end of a full 8-digit scan.

Function
REQ-011 SHALL run a prescaler cnt from 0 to SCAN_DIV-1, wrap it to 0, and assert internal tick when cnt==SCAN_DIV-1.
REQ-012 SHALL advance the 3-bit digit index idx on tick and wrap it from 7 to 0.
REQ-013 SHALL assert FRAME for exactly one cycle, on the cycle after a tick with idx==7.
REQ-014 SHALL, on LOAD, capture DATA and DP into a pending register and set pend_v; when several LOADs occur before a commit, the last one wins.
REQ-015 SHALL, on a tick with idx==7, copy pending into the display register when pend_v=1 and clear pend_v; no other event changes the display register (tear-free update).
REQ-016 SHALL, when LOAD coincides with a commit tick, commit the coinciding DATA/DP directly and leave pend_v=0.
REQ-017 SHALL register NA and SEG from the current idx and the display register, giving one cycle of latency from an idx change; NA = ~(1<<idx).
REQ-018 SHALL decode nibbles to SEG[6:0] as: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (hex values with dp off).
REQ-019 SHALL drive SEG[7]=0 when the displayed DP bit of idx is 1, including on blanked digits.
REQ-020 SHALL, with BLANK_LZ=1, force SEG[6:0]=7F on digit k>0 when display nibbles k..7 are all zero; digit 0 is never blanked.
REQ-021 SHALL sample BLANK_LZ live every cycle; it is not latched by LOAD.

Reset
REQ-022 SHALL, while RST=0 and independent of CLK, hold cnt=0, idx=0, display=0, pending=0, pend_v=0, NA=FF, SEG=FF, FRAME=0.
REQ-023 SHALL, on the first CLK edge after RST deasserts, drive NA=FE with SEG showing digit 0 of the zeroed display (C0).
REQ-024 SHALL discard any pending LOAD when reset is asserted mid-scan.

Structure
REQ-025 SHALL take the 16-entry hex-to-segment table, the SEG_OFF (FF) and NA_OFF (FF) constants, and the digit-count constant (8) from shared package seg7_pkg.
REQ-026 SHALL place the nibble-to-segment decode in a combinational sub-module seg7_decode; all other logic stays in seg7_scan.
REQ-027 SHALL implement the scan counters and registers in roughly 120-250 RTL lines in total.

Verification (SCAN_DIV=4)
REQ-028 SHALL verify reset: hold RST=0 mid-scan -> NA=FF, SEG=FF immediately; release -> next edge NA=FE, SEG=C0.
REQ-029 SHALL verify tear-free update: LOAD 0x12345678 at idx=3 -> digits 3..7 keep showing 0 until the frame wrap; then digit 0 shows SEG=80 with NA=FE, and digit 7 shows SEG=F9 with NA=7F.
REQ-030 SHALL verify leading-zero blanking: BLANK_LZ=1, DATA=0x00000A05 -> digit 0 SEG=92, digit 1 SEG=C0, digit 2 SEG=88, digits 3..7 SEG=FF; DATA=0 -> digit 0 SEG=C0, others FF.
REQ-031 SHALL verify LOAD coinciding with the commit tick -> new value shown from digit 0 of the next frame and pend_v=0.
REQ-032 SHALL verify the dp: DP=01 with nibble 8 -> digit 0 SEG=00; DP=80 with blanked digit 7 -> SEG=7F.
REQ-033 SHALL verify FRAME timing: FRAME pulses exactly once every 32 cycles, one cycle after the idx==7 tick.
